// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: generic pipeline stage register with a valid/ready handshake,
// a one-entry skid buffer, a synchronous flush and a saturating stall counter.
// In_Ready is decoded from registered state only, so back-pressure never forms
// a combinational path from one stage to the next.
module pipe_reg_skid #(
  parameter int                 DATA_W    = 96,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter bit                 NEG_EDGE  = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Flush,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_Data,
  input  logic              Out_Ready,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  // State is the pair {main_v, skid_v}; SKID_ONLY can never be reached.
  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    SKID_ONLY = 2'b01,
    ONE       = 2'b10,
    FULL      = 2'b11
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  main_d;
  logic [DATA_W-1:0]  skid_d;
  logic               main_v;
  logic               skid_v;
  logic               acc;
  logic               fire;
  logic               clk_act;

  // NOTE: the edge is chosen by inverting the clock once here rather than
  // duplicating every always_ff for each edge polarity.
  if (NEG_EDGE) begin : g_neg
    assign clk_act = ~Clk;
  end else begin : g_pos
    assign clk_act = Clk;
  end

  assign main_v    = state[1];
  assign skid_v    = state[0];
  assign Out_Valid = main_v;
  assign Out_Data  = main_d;
  assign In_Ready  = ~skid_v;
  assign Occupancy = {1'b0, main_v} + {1'b0, skid_v};

  assign acc  = In_Valid & In_Ready;
  assign fire = Out_Valid & Out_Ready;

  // Handshake state machine: main register feeds the output, skid register
  // catches the one beat that arrives while the output is stalled.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of its neighbours (main_d <= skid_d).
  always_ff @(posedge clk_act or posedge Clr) begin
    if (Clr) begin
      state  <= EMPTY;
      main_d <= NOP_VALUE;
      skid_d <= NOP_VALUE;
    end else if (Flush) begin
      // Flush beats any handshake, including a beat accepted on this edge.
      state  <= EMPTY;
      main_d <= NOP_VALUE;
      skid_d <= NOP_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_d <= In_Data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (fire && acc) begin
            main_d <= In_Data;
          end else if (fire) begin
            main_d <= NOP_VALUE;
            state  <= EMPTY;
          end else if (acc) begin
            skid_d <= In_Data;
            state  <= FULL;
          end
        end
        FULL: begin
          // In_Ready is low here, so only the drain path exists.
          if (fire) begin
            main_d <= skid_d;
            skid_d <= NOP_VALUE;
            state  <= ONE;
          end
        end
        default: begin
          // Recover from the unreachable skid-only encoding.
          state  <= EMPTY;
          main_d <= NOP_VALUE;
          skid_d <= NOP_VALUE;
        end
      endcase
    end
  end

  // Saturating count of edges where a valid output was held back downstream.
  always_ff @(posedge clk_act or posedge Clr) begin
    if (Clr) begin
      Stall_Cnt <= '0;
    end else if (Out_Valid && !Out_Ready && !Flush && (Stall_Cnt != {CNT_W{1'b1}})) begin
      Stall_Cnt <= Stall_Cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: a falling-edge 96-bit instance carries the
// stream, back-pressure, flush and reset scenarios; a 3-bit-counter instance
// shows saturation; a rising-edge instance repeats the stream. Drivers push
// expected beats into queues and per-instance monitors pop them on each fire.
module tb_pipe_reg_skid;

  localparam logic [95:0] NOP = 96'h0BAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, flush, in_valid, out_ready, in_ready, out_valid;
  logic [95:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic       s_valid, s_ready, s_in_ready, s_out_valid, s_flush;
  logic [7:0] s_data, s_out_data;
  logic [1:0] s_occ;
  logic [2:0] s_stall;

  logic       p_valid, p_ready, p_in_ready, p_out_valid, p_flush;
  logic [7:0] p_data, p_out_data;
  logic [1:0] p_occ;
  logic [15:0] p_stall;

  int n_cmp = 0;
  int n_bad = 0;
  logic [95:0] q_main[$];
  logic [7:0]  q_pos[$];

  pipe_reg_skid #(.DATA_W(96), .NOP_VALUE(NOP), .NEG_EDGE(1'b1), .CNT_W(16)) dut (
    .Clk(clk), .Clr(clr), .Flush(flush), .In_Valid(in_valid), .In_Data(in_data),
    .In_Ready(in_ready), .Out_Valid(out_valid), .Out_Data(out_data),
    .Out_Ready(out_ready), .Occupancy(occupancy), .Stall_Cnt(stall_cnt));

  pipe_reg_skid #(.DATA_W(8), .NOP_VALUE(8'h00), .NEG_EDGE(1'b1), .CNT_W(3)) dut_sat (
    .Clk(clk), .Clr(clr), .Flush(s_flush), .In_Valid(s_valid), .In_Data(s_data),
    .In_Ready(s_in_ready), .Out_Valid(s_out_valid), .Out_Data(s_out_data),
    .Out_Ready(s_ready), .Occupancy(s_occ), .Stall_Cnt(s_stall));

  pipe_reg_skid #(.DATA_W(8), .NOP_VALUE(8'h00), .NEG_EDGE(1'b0), .CNT_W(16)) dut_pos (
    .Clk(clk), .Clr(clr), .Flush(p_flush), .In_Valid(p_valid), .In_Data(p_data),
    .In_Ready(p_in_ready), .Out_Valid(p_out_valid), .Out_Data(p_out_data),
    .Out_Ready(p_ready), .Occupancy(p_occ), .Stall_Cnt(p_stall));

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Falling-edge instances: inputs change at posedge+1, so they are stable
  // across the next negedge; sample the handshake at posedge+2.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (out_valid && out_ready) begin
        if (q_main.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL main_unexpected_beat: got %0h, expected no beat", out_data);
        end else begin
          check("main_beat", out_data, q_main.pop_front());
        end
      end
    end
  end

  // Rising-edge instance: sample between edges, after inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (p_out_valid && p_ready) begin
        if (q_pos.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pos_unexpected_beat: got %0h, expected no beat", p_out_data);
        end else begin
          check("pos_beat", {88'h0, p_out_data}, {88'h0, q_pos.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One falling-edge cycle for the main instance; returns just after the edge.
  task automatic cyc(input logic v, input logic [95:0] d, input logic r,
                     input logic f, input logic push);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    if (push) q_main.push_back(d);
    @(negedge clk);
    #1;
  endtask

  // One cycle for the rising-edge instance; returns after the falling edge.
  task automatic pcyc(input logic v, input logic [7:0] d, input logic push);
    @(posedge clk);
    #1;
    p_valid = v;
    p_data  = d;
    p_ready = 1'b1;
    if (push) q_pos.push_back(d);
    @(negedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_ready = 1'b1; s_flush = 1'b0;
    p_valid = 1'b0; p_data = '0; p_ready = 1'b1; p_flush = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, NOP);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_occ", occupancy, 2'd0);
    check("rst_stall", stall_cnt, 16'd0);
    @(posedge clk);
    #1 clr = 1'b0;

    // Stream 1,2,3 at full throughput.
    cyc(1'b1, 96'h1, 1'b1, 1'b0, 1'b1);
    check("s1_data", out_data, 96'h1);
    check("s1_occ", occupancy, 2'd1);
    cyc(1'b1, 96'h2, 1'b1, 1'b0, 1'b1);
    check("s2_data", out_data, 96'h2);
    check("s2_occ", occupancy, 2'd1);
    cyc(1'b1, 96'h3, 1'b1, 1'b0, 1'b1);
    check("s3_data", out_data, 96'h3);
    check("s3_occ", occupancy, 2'd1);
    cyc(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
    check("s_drain_valid", out_valid, 1'b0);
    check("s_drain_data", out_data, NOP);
    check("s_stall", stall_cnt, 16'd0);

    // Back-pressure into the skid register.
    cyc(1'b1, 96'hA, 1'b1, 1'b0, 1'b1);
    check("bp_one_data", out_data, 96'hA);
    cyc(1'b1, 96'hB, 1'b0, 1'b0, 1'b1);
    check("bp_full_in_ready", in_ready, 1'b0);
    check("bp_full_occ", occupancy, 2'd2);
    check("bp_full_stall", stall_cnt, 16'd1);
    repeat (3) cyc(1'b1, 96'hC, 1'b0, 1'b0, 1'b0);
    check("bp_hold_stall", stall_cnt, 16'd4);
    check("bp_hold_occ", occupancy, 2'd2);
    check("bp_hold_data", out_data, 96'hA);
    cyc(1'b1, 96'hC, 1'b1, 1'b0, 1'b0);
    check("bp_drain_b", out_data, 96'hB);
    check("bp_drain_occ", occupancy, 2'd1);
    check("bp_drain_in_ready", in_ready, 1'b1);
    cyc(1'b1, 96'hC, 1'b1, 1'b0, 1'b1);
    check("bp_accept_c", out_data, 96'hC);
    cyc(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
    check("bp_end_occ", occupancy, 2'd0);
    check("bp_end_stall", stall_cnt, 16'd4);

    // Flush while FULL, with a beat offered on the flush edge.
    cyc(1'b1, 96'hA, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 96'hB, 1'b0, 1'b0, 1'b1);
    check("fl_pre_occ", occupancy, 2'd2);
    check("fl_pre_stall", stall_cnt, 16'd5);
    cyc(1'b1, 96'hD, 1'b0, 1'b1, 1'b0);
    q_main.delete();
    check("fl_occ", occupancy, 2'd0);
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_out_data", out_data, NOP);
    check("fl_in_ready", in_ready, 1'b1);
    check("fl_stall_kept", stall_cnt, 16'd5);
    cyc(1'b1, 96'hE, 1'b1, 1'b1, 1'b0);
    check("fl_empty_acc_dropped", occupancy, 2'd0);
    cyc(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
    check("fl_no_d", out_valid, 1'b0);

    // Asynchronous reset between edges while FULL.
    cyc(1'b1, 96'hA, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 96'hB, 1'b0, 1'b0, 1'b1);
    check("ar_pre_stall", stall_cnt, 16'd6);
    #2 clr = 1'b1;
    #1;
    q_main.delete();
    check("ar_out_valid", out_valid, 1'b0);
    check("ar_in_ready", in_ready, 1'b1);
    check("ar_stall", stall_cnt, 16'd0);
    check("ar_occ", occupancy, 2'd0);
    check("ar_out_data", out_data, NOP);
    cyc(1'b1, 96'hF, 1'b1, 1'b0, 1'b0);
    check("ar_no_accept", occupancy, 2'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    cyc(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
    check("ar_release_occ", occupancy, 2'd0);

    // Stall counter saturation on the 3-bit instance.
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    s_ready = 1'b0;
    @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("sat_six", s_stall, 3'd6);
    repeat (4) @(negedge clk);
    #1;
    check("sat_stop", s_stall, 3'd7);
    check("sat_occ", s_occ, 2'd1);
    check("sat_data", s_out_data, 8'h55);

    // Rising-edge instance: new inputs are present at every falling edge,
    // so a falling-edge update would show up in these checks.
    pcyc(1'b1, 8'h1, 1'b1);
    check("pos_idle_valid", p_out_valid, 1'b0);
    pcyc(1'b1, 8'h2, 1'b1);
    check("pos_d1", p_out_data, 8'h1);
    pcyc(1'b1, 8'h3, 1'b1);
    check("pos_d2", p_out_data, 8'h2);
    check("pos_occ", p_occ, 2'd1);
    pcyc(1'b0, 8'h0, 1'b0);
    check("pos_d3", p_out_data, 8'h3);
    pcyc(1'b0, 8'h0, 1'b0);
    check("pos_drain_valid", p_out_valid, 1'b0);
    check("pos_stall", p_stall, 16'd0);

    repeat (2) @(posedge clk);
    #3;
    check("main_queue_empty", q_main.size(), 96'd0);
    check("pos_queue_empty", q_pos.size(), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
Parametrised successor to the fixed IF/ID-style stage register. It carries a DATA_W-bit payload between two pipeline stages with a valid/ready handshake, a one-entry skid buffer, a synchronous flush, and a saturating stall counter. The block is generic: IF/ID, ID/EX, EX/MEM and MEM/WB are instances with different DATA_W and NOP_VALUE. Because In_Ready is registered, back-pressure never forms a combinational path across stages.

Parameters:
DATA_W, 96, payload width in bits (e.g. PC4+PC+Inst = 96).
NOP_VALUE, {DATA_W{1'b0}}, value loaded into the data registers on reset and flush (a bubble).
NEG_EDGE, 1, 1 = registers update on the falling edge of Clk; 0 = rising edge.
CNT_W, 16, width of the stall counter.

Ports:
Clk  input  1  clock; the active edge is selected by NEG_EDGE.
Clr  input  1  asynchronous reset, active-high.
Flush  input  1  synchronous flush, active-high; sampled on the active edge.
In_Valid  input  1  upstream has a beat.
In_Data  input  DATA_W  upstream payload.
In_Ready  output  1  block can accept a beat; driven only from state.
Out_Valid  output  1  Out_Data holds a valid beat.
Out_Data  output  DATA_W  downstream payload; driven by the main register.
Out_Ready  input  1  downstream accepts the beat.
Occupancy  output  2  number of held beats: 0, 1 or 2.
Stall_Cnt  output  CNT_W  active edges on which Out_Valid=1 and Out_Ready=0.

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- Output mapping: Out_Valid=main_v; Out_Data=main_d; In_Ready=~skid_v; Occupancy=main_v+skid_v.
- Beat definitions: acc = In_Valid & In_Ready; fire = Out_Valid & Out_Ready.
- States are encoded by {main_v, skid_v}:
  - EMPTY (00):
    - acc: main<=In_Data, go ONE.
    - no acc: stay.
  - ONE (10):
    - fire & acc: main<=In_Data, stay ONE.
    - fire only: go EMPTY; main_d<=NOP_VALUE.
    - acc only: skid<=In_Data, go FULL.
    - neither: hold.
  - FULL (11), In_Ready=0:
    - fire: main<=skid_d, skid_d<=NOP_VALUE, go ONE.
    - no fire: hold.
  - State 01 is illegal and unreachable. If it is ever entered, the next edge goes to EMPTY.
- Ordering: beats leave in strict acceptance order. No beat is lost or duplicated.
- Latency: a beat accepted on edge N is visible on Out_Data after edge N. This is the same 1-edge latency as the legacy stage register. Throughput is 1 beat per edge while Out_Ready=1.
- Flush:
  - On the active edge with Flush=1: main_v=skid_v=0, both data registers <= NOP_VALUE.
  - A beat accepted on that same edge is discarded.
  - Flush has priority over all handshake activity.
  - Stall_Cnt is unaffected by Flush.
- Stall counter:
  - Increments on each active edge where Out_Valid & ~Out_Ready & ~Flush.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset (Clr=1, asynchronous, takes effect immediately, mid-transfer included):
  - main_v=skid_v=0, main_d=skid_d=NOP_VALUE, Stall_Cnt=0.
  - Resulting outputs: Out_Valid=0, Out_Data=NOP_VALUE, In_Ready=1, Occupancy=0.
  - Release is synchronous to the next active edge. No beat is accepted on an edge where Clr=1.
- Stability: In_Data may change while In_Ready=0; the block ignores it.
- Simultaneous events:
  - Flush=1 with Clr=1 → reset wins.
  - fire+acc in FULL cannot occur, because In_Ready=0 in FULL.

Test Plan:
- Reset then stream: Clr pulse; In_Valid=1 with data 0x1,0x2,0x3 on consecutive edges, Out_Ready=1 → Out_Data shows 0x1,0x2,0x3 one edge after each accept; Occupancy stays 1; Stall_Cnt=0.
- Back-pressure/skid: hold ONE with 0xA; drop Out_Ready, present 0xB → FULL, In_Ready=0, Occupancy=2. Present 0xC for 3 edges → ignored; Stall_Cnt=4. Raise Out_Ready → outputs 0xA, then 0xB, then 0xC is accepted.
- Flush in FULL: state FULL (0xA, 0xB), Flush=1 with In_Valid=1 and data 0xD → next edge Occupancy=0, Out_Valid=0, Out_Data=NOP_VALUE, 0xD is not output; Stall_Cnt retained.
- Async reset mid-operation: state FULL, assert Clr between edges → outputs clear immediately with no edge: Out_Valid=0, In_Ready=1, Stall_Cnt=0.
- Counter saturation: CNT_W=3, Out_Ready=0 with a valid beat for 10 edges → Stall_Cnt stops at 7.
- Edge mode: NEG_EDGE=0, repeat the stream test → updates occur on rising edges only; no change on falling edges.
